reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
In-order retirement buffer on the responder side of the reservation-station dispatch path.
- Grants a ROB entry number to each dispatched instruction.
- Records completion broadcasts from the three functional units (fu1/fu2 arithmetic, fu3 memory).
- Retires completed entries strictly in program order, up to 2 per cycle.
- Retired p_rd goes to the architectural commit; retired p_old_rd goes to the free list.

Parameters:
ROB_ROW_COUNT, 64, number of entries; power of 2, at least 4.
IDX_W, $clog2(ROB_ROW_COUNT), entry index width (derived localparam).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
alloc_valid  input  1  dispatch requests one entry this cycle.
alloc_ready  output  1  entry available; high when count < ROB_ROW_COUNT.
alloc_rob_num  output  IDX_W  index granted (current head pointer); valid while alloc_ready.
alloc_p_rd  input  6  destination physical register.
alloc_p_old_rd  input  6  previous mapping of the architectural rd.
alloc_has_rd  input  1  instruction writes a register.
cmp_valid  input  3  per-FU completion strobe (bit0 fu1, bit1 fu2, bit2 fu3).
cmp_rob_num  input  3*IDX_W  per-FU completing entry index, packed fu1 in LSBs.
ret_valid  output  2  retire slot valid (slot0 oldest).
ret_p_rd  output  12  per-slot retired p_rd, slot0 in [5:0].
ret_p_old_rd  output  12  per-slot register to free, slot0 in [5:0].
ret_has_rd  output  2  per-slot has_rd.
rob_count  output  IDX_W+1  occupied entries.
rob_empty  output  1  count == 0.

Behaviour:
- Storage: per entry valid, complete, has_rd, p_rd[5:0], p_old_rd[5:0]. Head (alloc) and tail (retire) pointers are IDX_W+1 bits; the MSB disambiguates full from empty.
- Reset (async, any cycle including mid-operation):
  - all valid/complete bits cleared; head = tail = 0; count = 0.
  - outputs: alloc_ready=1, alloc_rob_num=0, ret_valid=0, ret_* = 0, rob_count=0, rob_empty=1.
- Allocation:
  - fires when alloc_valid & alloc_ready.
  - Next edge: entry[head] gets valid=1, complete=0 and the alloc fields; head += 1 with natural wrap.
  - alloc_ready is derived from registered count only. A retirement in the same cycle does not unblock a full ROB (no bypass).
  - alloc_valid while !alloc_ready: ignored, no state change.
- Completion:
  - each set cmp_valid bit sets complete on the addressed entry at the next edge.
  - Completion to an entry with valid=0 is ignored.
  - Multiple ports naming the same entry: idempotent.
- Retirement (combinational outputs from registered state):
  - slot0 valid iff entry[tail] valid & complete.
  - slot1 valid iff slot0 valid & entry[tail+1] valid & complete (index wraps).
  - On the edge: retired entries clear valid/complete; tail += number retired (0..2).
  - Completion of the head-of-line entry in cycle N retires no earlier than cycle N+1 (ret_valid visible in N+1).
- Count update: count_next = count + alloc_fire - retire_n. Simultaneous alloc and retire are legal in the same cycle.
- Wrap-around: indices taken modulo ROB_ROW_COUNT; entries at 63 and 0 retire together as slot0/slot1.
- Latency: alloc to earliest retire is 2 cycles (alloc edge, completion edge, retire visible the following cycle).
- No flush/exception support in this revision; reset is the only way to clear in-flight entries.

Decomposition:
- Shared package RSTableROBStruct gets:
  - rob_entry_t struct (valid, complete, has_rd, p_rd, p_old_rd).
  - FU index constants FU_ARITH0=0, FU_ARITH1=1, FU_MEM=2.
  - NUM_FU=3, RETIRE_WIDTH=2, PREG_W=6.
- One natural sub-module: rob_ptr_ctrl, holding the head/tail/count registers and the full/empty logic. Entry array and retire select stay in the top.

Test Plan:
- Reset then 3 allocs (p_rd 10,11,12; p_old_rd 1,2,3) -> alloc_rob_num 0,1,2; rob_count=3; ret_valid=00.
- Complete entry 1 only, then entry 0 -> no retire until entry 0 completes. Next cycle ret_valid=11, ret_p_old_rd={2,1}; then rob_count=1.
- Fill 64 entries -> alloc_ready=0. Assert alloc_valid plus a retire of entry 0 in the same cycle -> no alloc that cycle; alloc_ready=1 the next cycle, with alloc_rob_num=0.
- Wrap: head at 63, alloc 2 -> indices 63, 0. Complete both via fu1 and fu3 in one cycle -> retire both in one cycle, slot0=63.
- Completion strobe to an invalid entry 5 with ROB empty -> no state change. A later alloc at index 5 has complete=0 and does not retire.
- Assert reset mid-run with count=20 and completions pending -> outputs immediately at reset values; after release the first alloc gets index 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
// Holds the per-entry record, functional-unit indices and datapath widths.
package RSTableROBStruct;

    localparam int NUM_FU       = 3;
    localparam int RETIRE_WIDTH = 2;
    localparam int PREG_W       = 6;

    localparam int FU_ARITH0 = 0;
    localparam int FU_ARITH1 = 1;
    localparam int FU_MEM    = 2;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic              has_rd;
        logic [PREG_W-1:0] p_rd;
        logic [PREG_W-1:0] p_old_rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer.
// Ports: clk, reset (async high); alloc_valid_i, retire_n_i in;
//        alloc_fire_o, alloc_ready_o, head_idx_o, tail_idx_o,
//        count_o, empty_o out.
module rob_ptr_ctrl #(
    parameter  int ROB_ROW_COUNT = 64,
    localparam int IDX_W         = $clog2(ROB_ROW_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid_i,
    input  logic [1:0]       retire_n_i,
    output logic             alloc_fire_o,
    output logic             alloc_ready_o,
    output logic [IDX_W-1:0] head_idx_o,
    output logic [IDX_W-1:0] tail_idx_o,
    output logic [IDX_W:0]   count_o,
    output logic             empty_o
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Ready looks only at the registered count: a retire in the
    // same cycle never frees a slot for a simultaneous alloc.
    assign alloc_ready_o = count_q < CW'(ROB_ROW_COUNT);
    assign alloc_fire_o  = alloc_valid_i & alloc_ready_o;

    assign head_idx_o = head_q[IDX_W-1:0];
    assign tail_idx_o = tail_q[IDX_W-1:0];
    assign count_o    = count_q;
    assign empty_o    = count_q == '0;

    always_comb begin
        head_d  = head_q + CW'(alloc_fire_o);
        tail_d  = tail_q + CW'(retire_n_i);
        count_d = count_q + CW'(alloc_fire_o) - CW'(retire_n_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: grants entries, records FU completions,
// retires up to two completed entries per cycle in program order.
// Ports: clk, reset (async high);
//   alloc_valid/p_rd/p_old_rd/has_rd in, alloc_ready/rob_num out;
//   cmp_valid[3], cmp_rob_num[3*IDX_W] in (fu1 in LSBs);
//   ret_valid/p_rd/p_old_rd/has_rd out (slot0 in LSBs);
//   rob_count, rob_empty out.
module reorder_buffer
    import RSTableROBStruct::*;
#(
    parameter  int ROB_ROW_COUNT = 64,
    localparam int IDX_W         = $clog2(ROB_ROW_COUNT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    output logic [IDX_W-1:0]               alloc_rob_num,
    input  logic [PREG_W-1:0]              alloc_p_rd,
    input  logic [PREG_W-1:0]              alloc_p_old_rd,
    input  logic                           alloc_has_rd,
    input  logic [NUM_FU-1:0]              cmp_valid,
    input  logic [NUM_FU*IDX_W-1:0]        cmp_rob_num,
    output logic [RETIRE_WIDTH-1:0]        ret_valid,
    output logic [RETIRE_WIDTH*PREG_W-1:0] ret_p_rd,
    output logic [RETIRE_WIDTH*PREG_W-1:0] ret_p_old_rd,
    output logic [RETIRE_WIDTH-1:0]        ret_has_rd,
    output logic [IDX_W:0]                 rob_count,
    output logic                           rob_empty
);

    rob_entry_t ent_q [ROB_ROW_COUNT];
    rob_entry_t ent_d [ROB_ROW_COUNT];

    logic             alloc_fire;
    logic [1:0]       retire_n;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] t0, t1;
    rob_entry_t       e0, e1;
    logic             slot0, slot1;

    rob_ptr_ctrl #(
        .ROB_ROW_COUNT(ROB_ROW_COUNT)
    ) u_ptr (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid_i(alloc_valid),
        .retire_n_i   (retire_n),
        .alloc_fire_o (alloc_fire),
        .alloc_ready_o(alloc_ready),
        .head_idx_o   (head_idx),
        .tail_idx_o   (t0),
        .count_o      (rob_count),
        .empty_o      (rob_empty)
    );

    assign alloc_rob_num = head_idx;

    // Second retire slot index wraps naturally in IDX_W bits.
    assign t1 = t0 + IDX_W'(1);
    assign e0 = ent_q[t0];
    assign e1 = ent_q[t1];

    assign slot0    = e0.valid & e0.complete;
    assign slot1    = slot0 & e1.valid & e1.complete;
    assign retire_n = slot1 ? 2'd2 : {1'b0, slot0};

    // Slot data is zeroed when the slot is not retiring.
    assign ret_valid    = {slot1, slot0};
    assign ret_has_rd   = {slot1 & e1.has_rd, slot0 & e0.has_rd};
    assign ret_p_rd     = {{PREG_W{slot1}} & e1.p_rd,
                           {PREG_W{slot0}} & e0.p_rd};
    assign ret_p_old_rd = {{PREG_W{slot1}} & e1.p_old_rd,
                           {PREG_W{slot0}} & e0.p_old_rd};

    // Completion only marks live entries; a slot being allocated
    // this cycle is still invalid, so it always starts incomplete.
    always_comb begin
        ent_d = ent_q;
        for (int f = 0; f < NUM_FU; f++) begin
            if (cmp_valid[f] &&
                ent_q[cmp_rob_num[f*IDX_W +: IDX_W]].valid) begin
                ent_d[cmp_rob_num[f*IDX_W +: IDX_W]].complete = 1'b1;
            end
        end
        if (slot0) begin
            ent_d[t0].valid    = 1'b0;
            ent_d[t0].complete = 1'b0;
        end
        if (slot1) begin
            ent_d[t1].valid    = 1'b0;
            ent_d[t1].complete = 1'b0;
        end
        if (alloc_fire) begin
            ent_d[head_idx].valid    = 1'b1;
            ent_d[head_idx].complete = 1'b0;
            ent_d[head_idx].has_rd   = alloc_has_rd;
            ent_d[head_idx].p_rd     = alloc_p_rd;
            ent_d[head_idx].p_old_rd = alloc_p_old_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_ROW_COUNT; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table, directed
// corner sequences and a random run against a queue-based model.
module tb_reorder_buffer;

    localparam int N  = 64;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic [IW-1:0] alloc_rob_num;
    logic [5:0]    alloc_p_rd = '0;
    logic [5:0]    alloc_p_old_rd = '0;
    logic          alloc_has_rd = 1'b0;
    logic [2:0]    cmp_valid = '0;
    logic [3*IW-1:0] cmp_rob_num = '0;
    logic [1:0]    ret_valid;
    logic [11:0]   ret_p_rd;
    logic [11:0]   ret_p_old_rd;
    logic [1:0]    ret_has_rd;
    logic [IW:0]   rob_count;
    logic          rob_empty;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_ROW_COUNT(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_rob_num (alloc_rob_num),
        .alloc_p_rd    (alloc_p_rd),
        .alloc_p_old_rd(alloc_p_old_rd),
        .alloc_has_rd  (alloc_has_rd),
        .cmp_valid     (cmp_valid),
        .cmp_rob_num   (cmp_rob_num),
        .ret_valid     (ret_valid),
        .ret_p_rd      (ret_p_rd),
        .ret_p_old_rd  (ret_p_old_rd),
        .ret_has_rd    (ret_has_rd),
        .rob_count     (rob_count),
        .rob_empty     (rob_empty)
    );

    // Reference model: program-ordered queue of in-flight instructions.
    typedef struct {
        int         idx;
        logic [5:0] prd;
        logic [5:0] pold;
        logic       hrd;
        logic       comp;
    } mrec_t;

    mrec_t q[$];
    int    next_idx = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic [1:0]  rv;
        logic [11:0] rp;
        logic [11:0] ro;
        logic [1:0]  rh;
        rv = '0; rp = '0; ro = '0; rh = '0;
        if (q.size() > 0 && q[0].comp) begin
            rv[0] = 1'b1; rp[5:0] = q[0].prd;
            ro[5:0] = q[0].pold; rh[0] = q[0].hrd;
            if (q.size() > 1 && q[1].comp) begin
                rv[1] = 1'b1; rp[11:6] = q[1].prd;
                ro[11:6] = q[1].pold; rh[1] = q[1].hrd;
            end
        end
        chk("m_alloc_ready", 32'(alloc_ready), 32'(q.size() < N));
        chk("m_alloc_rob_num", 32'(alloc_rob_num), 32'(next_idx));
        chk("m_ret_valid", 32'(ret_valid), 32'(rv));
        chk("m_ret_p_rd", 32'(ret_p_rd), 32'(rp));
        chk("m_ret_p_old_rd", 32'(ret_p_old_rd), 32'(ro));
        chk("m_ret_has_rd", 32'(ret_has_rd), 32'(rh));
        chk("m_rob_count", 32'(rob_count), 32'(q.size()));
        chk("m_rob_empty", 32'(rob_empty), 32'(q.size() == 0));
    endtask

    // Called at a falling edge: drive, advance model, clock, check.
    task automatic cycle(input logic av, input logic [5:0] prd,
                         input logic [5:0] pold, input logic hrd,
                         input logic [2:0] cv, input int c0,
                         input int c1, input int c2);
        int   n;
        int   cs[3];
        logic fire;
        alloc_valid    = av;
        alloc_p_rd     = prd;
        alloc_p_old_rd = pold;
        alloc_has_rd   = hrd;
        cmp_valid      = cv;
        cmp_rob_num    = {6'(c2), 6'(c1), 6'(c0)};
        cs = '{c0, c1, c2};
        fire = av && (q.size() < N);
        n = 0;
        if (q.size() > 0 && q[0].comp) begin
            n = 1;
            if (q.size() > 1 && q[1].comp) n = 2;
        end
        for (int f = 0; f < 3; f++) begin
            if (cv[f]) begin
                foreach (q[k]) if (q[k].idx == cs[f]) q[k].comp = 1'b1;
            end
        end
        repeat (n) void'(q.pop_front());
        if (fire) begin
            q.push_back('{idx: next_idx, prd: prd, pold: pold,
                          hrd: hrd, comp: 1'b0});
            next_idx = (next_idx + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 6'd0, 6'd0, 1'b0, 3'b000, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        alloc_valid = 1'b0;
        cmp_valid   = '0;
        q.delete();
        next_idx = 0;
        #1;
        model_check();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        av;
        logic [5:0]  prd;
        logic [5:0]  pold;
        logic [2:0]  cv;
        logic [5:0]  c0;
        logic [5:0]  c2;
        logic [6:0]  e_cnt;
        logic [1:0]  e_rv;
        logic [11:0] e_old;
        logic [5:0]  e_num;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 6'd10, 6'd1, 3'b000, 6'd0, 6'd0, 7'd1, 2'b00, 12'h000, 6'd1};
        vt[1] = '{1'b1, 6'd11, 6'd2, 3'b000, 6'd0, 6'd0, 7'd2, 2'b00, 12'h000, 6'd2};
        vt[2] = '{1'b1, 6'd12, 6'd3, 3'b000, 6'd0, 6'd0, 7'd3, 2'b00, 12'h000, 6'd3};
        vt[3] = '{1'b0, 6'd0, 6'd0, 3'b001, 6'd1, 6'd0, 7'd3, 2'b00, 12'h000, 6'd3};
        vt[4] = '{1'b0, 6'd0, 6'd0, 3'b001, 6'd0, 6'd0, 7'd3, 2'b11, 12'h081, 6'd3};
        vt[5] = '{1'b0, 6'd0, 6'd0, 3'b000, 6'd0, 6'd0, 7'd1, 2'b00, 12'h000, 6'd3};
        vt[6] = '{1'b0, 6'd0, 6'd0, 3'b100, 6'd0, 6'd2, 7'd1, 2'b01, 12'h003, 6'd3};
        vt[7] = '{1'b0, 6'd0, 6'd0, 3'b000, 6'd0, 6'd0, 7'd0, 2'b00, 12'h000, 6'd3};

        @(negedge clk);
        do_reset();
        chk("reset_ready", 32'(alloc_ready), 32'd1);
        chk("reset_empty", 32'(rob_empty), 32'd1);
        chk("reset_rob_num", 32'(alloc_rob_num), 32'd0);

        // Vector table: allocs, out-of-order completion, dual retire.
        for (int i = 0; i < 8; i++) begin
            cycle(vt[i].av, vt[i].prd, vt[i].pold, 1'b1, vt[i].cv,
                  int'(vt[i].c0), 0, int'(vt[i].c2));
            chk($sformatf("vec%0d_count", i), 32'(rob_count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_ret_valid", i), 32'(ret_valid), 32'(vt[i].e_rv));
            chk($sformatf("vec%0d_ret_old", i), 32'(ret_p_old_rd), 32'(vt[i].e_old));
            chk($sformatf("vec%0d_rob_num", i), 32'(alloc_rob_num), 32'(vt[i].e_num));
        end

        // Full ROB: retire in the same cycle does not admit an alloc.
        do_reset();
        for (int i = 0; i < N; i++)
            cycle(1'b1, 6'(i), 6'(63 - i), i[0], 3'b000, 0, 0, 0);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_count", 32'(rob_count), 32'd64);
        cycle(1'b0, 6'd0, 6'd0, 1'b0, 3'b001, 0, 0, 0);
        chk("full_ret_valid", 32'(ret_valid), 32'b01);
        cycle(1'b1, 6'd7, 6'd7, 1'b1, 3'b000, 0, 0, 0);
        chk("full_noalloc_count", 32'(rob_count), 32'd63);
        chk("full_ready_after", 32'(alloc_ready), 32'd1);
        chk("full_rob_num_after", 32'(alloc_rob_num), 32'd0);
        cycle(1'b1, 6'd7, 6'd7, 1'b1, 3'b000, 0, 0, 0);
        chk("full_realloc_count", 32'(rob_count), 32'd64);

        // Wrap: entries 63 and 0 retire together.
        do_reset();
        for (int i = 0; i < 63; i++)
            cycle(1'b1, 6'(i), 6'(i), 1'b1, (i > 0) ? 3'b001 : 3'b000,
                  (i > 0) ? i - 1 : 0, 0, 0);
        cycle(1'b0, 6'd0, 6'd0, 1'b0, 3'b001, 62, 0, 0);
        idle(2);
        chk("wrap_head", 32'(alloc_rob_num), 32'd63);
        chk("wrap_empty", 32'(rob_empty), 32'd1);
        cycle(1'b1, 6'd40, 6'd50, 1'b1, 3'b000, 0, 0, 0);
        cycle(1'b1, 6'd41, 6'd51, 1'b0, 3'b000, 0, 0, 0);
        cycle(1'b0, 6'd0, 6'd0, 1'b0, 3'b101, 63, 0, 0);
        chk("wrap_ret_valid", 32'(ret_valid), 32'b11);
        chk("wrap_ret_p_rd", 32'(ret_p_rd), 32'((41 << 6) | 40));
        chk("wrap_ret_has_rd", 32'(ret_has_rd), 32'b01);
        idle(1);
        chk("wrap_drained", 32'(rob_count), 32'd0);

        // Completion to an invalid entry is dropped.
        do_reset();
        cycle(1'b0, 6'd0, 6'd0, 1'b0, 3'b001, 5, 0, 0);
        chk("inv_empty", 32'(rob_empty), 32'd1);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 6'(20 + i), 6'(i), 1'b1, 3'b000, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 6'd0, 6'd0, 1'b0, 3'b001, i, 0, 0);
        idle(3);
        chk("inv_count", 32'(rob_count), 32'd1);
        chk("inv_no_retire", 32'(ret_valid), 32'd0);

        // Asynchronous reset mid-run with completions pending.
        do_reset();
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 6'(i), 6'(i), 1'b1, 3'b000, 0, 0, 0);
        chk("mid_count", 32'(rob_count), 32'd20);
        cmp_valid   = 3'b111;
        cmp_rob_num = {6'd5, 6'd4, 6'd3};
        #2;
        reset = 1'b1;
        q.delete();
        next_idx = 0;
        #1;
        chk("mid_rst_count", 32'(rob_count), 32'd0);
        chk("mid_rst_ret", 32'(ret_valid), 32'd0);
        chk("mid_rst_ready", 32'(alloc_ready), 32'd1);
        model_check();
        @(negedge clk);
        reset = 1'b0;
        cmp_valid = '0;
        chk("mid_post_num", 32'(alloc_rob_num), 32'd0);
        cycle(1'b1, 6'd9, 6'd9, 1'b1, 3'b000, 0, 0, 0);
        chk("mid_post_count", 32'(rob_count), 32'd1);

        // Random traffic in phases of varying pressure.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          ph;
            int          ap;
            int          cp;
            logic [2:0]  cv;
            int          c[3];
            ph = cyc / 500;
            ap = (ph % 2 == 0) ? 80 : 30;
            cp = (ph == 2) ? 5 : 30;
            for (int f = 0; f < 3; f++) begin
                cv[f] = ($urandom_range(99) < cp);
                if (q.size() > 0 && $urandom_range(7) != 0)
                    c[f] = q[$urandom_range(q.size() - 1)].idx;
                else
                    c[f] = $urandom_range(N - 1);
            end
            cycle($urandom_range(99) < ap, 6'($urandom), 6'($urandom),
                  1'($urandom), cv, c[0], c[1], c[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
